spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- SPI mode-0 write-only target that turns serial frames from ui_in pins into the five PWM control registers consumed by pwm_peripheral.
- Sits directly upstream of pwm_peripheral: its register outputs drive en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- SPI pins are asynchronous to clk. The block synchronizes and edge-detects them, then shifts, validates and commits each frame.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer chain (legal ≥2); the edge-detect flop is extra.
- MAX_ADDR, 4, highest writable register address; frames addressed above it are discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- spi_sclk  input  1  SPI clock, async
- spi_copi  input  1  SPI data in, async
- spi_ncs  input  1  SPI chip select, active-low, async
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_strobe  output  1  one-clk pulse when a register is committed
- frame_err  output  1  one-clk pulse when a completed frame is discarded

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: all five registers are 0x00; wr_strobe=0; frame_err=0; shift register 0; bit counter 0; FSM in IDLE. Synchronizer flops reset to the idle levels: sclk=0, copi=0, ncs=1.
- Synchronization: each pin passes through SYNC_STAGES flops plus one history flop.
  - sclk_rise = sync & ~hist.
  - ncs_fall and ncs_rise are derived the same way.
- Frame format, MSB first, 16 bits:
  - bit15 is R/W; 1 means write.
  - bits14:8 are the 7-bit address.
  - bits7:0 are the data.
- COPI is sampled on sclk_rise only while synced ncs=0.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on ncs_fall. The bit counter clears and the shift register clears.
  - SHIFT: each sclk_rise shifts in synced copi and increments the counter. The counter saturates at 17, meaning more than 16 bits were received.
  - SHIFT -> COMMIT on ncs_rise.
  - COMMIT lasts exactly one clk, then the FSM returns to IDLE.
- Commit rule (evaluated in COMMIT): the frame is valid only if counter==16, R/W=1 and addr≤MAX_ADDR.
  - Valid: write data to the addressed register and pulse wr_strobe in the same cycle. The new value is visible on the output from the next clk edge.
  - Invalid (counter≠16, R/W=0, or addr>MAX_ADDR): no register changes; pulse frame_err.
- Latency from the spi_ncs pin rising to the register update: SYNC_STAGES+2 clk edges (3 sync/hist edges + COMMIT at default).
- sclk edges while ncs=1 are ignored.
- ncs_rise while in IDLE (glitch or a reset released mid-frame): ignored, no frame_err.
- ncs_fall while in SHIFT cannot occur without a prior rise. A rise and fall within the synchronizer window is treated as a single continuous frame (documented limitation).
- Reset asserted mid-frame aborts the frame. Register values revert to 0x00.
- Back-to-back frames: the next ncs_fall may land in the COMMIT cycle. COMMIT must still return to IDLE, and IDLE samples ncs_fall on the following cycle. Because of the hist flop, a fall coinciding with COMMIT is missed. The host therefore keeps ncs high for ≥ SYNC_STAGES+3 clk cycles.
- Host SCLK must stay ≤ clk/4 (high and low each ≥2 clk) for reliable sampling.

Decomposition:
- Shared package spi_reg_pkg:
  - address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04
  - FRAME_BITS=16
  - FSM state enum.
- One sub-module: spi_sync_edge, one instance per pin. It holds the SYNC_STAGES chain plus the hist flop and outputs sync, rise and fall.

Test Plan:
- Reset: assert rst mid-run -> all registers 0x00, wr_strobe=0, frame_err=0.
- Write frame 0x8455 (write, addr 0x04, data 0x55) at sclk=clk/8 -> pwm_duty_cycle=0x55 exactly SYNC_STAGES+2 clk after the ncs pin rises; one wr_strobe pulse; other registers unchanged.
- Writes to addr 0x00–0x03 with 0xA5, 0x5A, 0xFF, 0x01 -> each lands in its own register only; four wr_strobe pulses.
- Invalid frames:
  - 0x0412 (R/W=0) -> frame_err pulse, no change.
  - 0x8512 (addr 5) -> frame_err pulse, no change.
  - 15-bit frame -> frame_err pulse, no change.
  - 17-bit frame -> frame_err pulse, no change.
- SCLK toggling with ncs=1, followed by a valid frame 0x8133 -> no effect from the idle toggles; en_reg_out_15_8=0x33.
- Abort: 8 bits into frame 0x82FF assert rst, release it, then send 0x8207 -> en_reg_pwm_7_0=0x07 and no frame_err pulse from the aborted frame.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register-write target.
package spi_reg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, plus a history flop for edge detect.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], pin_i};
      hist_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only target: shifts 16-bit frames, validates them and
// commits the data byte into one of five PWM control registers.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_copi,
  input  logic       spi_ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);
  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic copi_sync, copi_rise, copi_fall;
  logic ncs_sync, ncs_rise, ncs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .pin_i(spi_sclk),
    .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .pin_i(spi_copi),
    .sync_o(copi_sync), .rise_o(copi_rise), .fall_o(copi_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .pin_i(spi_ncs),
    .sync_o(ncs_sync), .rise_o(ncs_rise), .fall_o(ncs_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_sync, sclk_fall, copi_rise, copi_fall};

  state_e                       state_q, state_d;
  logic [FRAME_BITS-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_REGS-1:0][7:0]     regs_q, regs_d;
  logic                         frame_ok;

  assign frame_ok = (cnt_q == CNT_FULL) && shift_q[15] && (shift_q[14:8] <= MAX_A);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    wr_strobe = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise && !ncs_sync) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_sync};
          // Saturation at 17 keeps overlong frames distinguishable from 16-bit ones.
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (ncs_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          wr_strobe = 1'b1;
          for (int i = 0; i < NUM_REGS; i++)
            if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized + directed bench for spi_reg_ctrl against a frame-level register model.
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0, spi_copi = 1'b0, spi_ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic wr_strobe, frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_ncs(spi_ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int wr_cnt = 0, err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one pending commit per frame, due SYNC_STAGES+1 edges after the ncs pin rises.
  typedef struct { int cyc; bit ok; int addr; logic [7:0] data; } ev_t;
  ev_t evq[$];
  logic [7:0] mreg [5];

  always @(negedge clk) begin
    bit exp_wr, exp_err;
    exp_wr = 0; exp_err = 0;
    if (rst) begin
      evq.delete();
      for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    end else if (evq.size() > 0) begin
      if (cyc == evq[0].cyc) begin
        exp_wr = evq[0].ok; exp_err = !evq[0].ok;
      end else if (cyc == evq[0].cyc + 1) begin
        if (evq[0].ok) mreg[evq[0].addr] = evq[0].data;
        void'(evq.pop_front());
      end
    end
    chk("reg0", r0, mreg[0]);
    chk("reg1", r1, mreg[1]);
    chk("reg2", r2, mreg[2]);
    chk("reg3", r3, mreg[3]);
    chk("reg4", r4, mreg[4]);
    chk("wr_strobe", wr_strobe, exp_wr);
    chk("frame_err", frame_err, exp_err);
    if (wr_strobe) wr_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low n bits of w MSB first; optionally closes the frame.
  task automatic send(input logic [31:0] w, input int n, input int half, input bit close = 1);
    ev_t e;
    @(negedge clk);
    spi_ncs = 1'b0;
    clk_wait(half + 2);
    for (int i = n - 1; i >= 0; i--) begin
      spi_copi = w[i];
      clk_wait(half);
      spi_sclk = 1'b1;
      clk_wait(half);
      spi_sclk = 1'b0;
    end
    if (close) begin
      clk_wait(half);
      spi_ncs = 1'b1;
      e.cyc  = cyc + 3;
      e.addr = int'(w[14:8]);
      e.data = w[7:0];
      e.ok   = (n == 16) && w[15] && (w[14:8] <= 7'd4);
      evq.push_back(e);
      clk_wait(8);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; spi_ncs = 1'b1; spi_sclk = 1'b0; spi_copi = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    clk_wait(4);
  endtask

  task automatic idle_toggles(input int n);
    for (int i = 0; i < n; i++) begin
      spi_copi = 1'($urandom);
      clk_wait(2); spi_sclk = 1'b1;
      clk_wait(2); spi_sclk = 1'b0;
    end
    clk_wait(4);
  endtask

  initial begin
    int w0, e0, half, n, kind;
    logic [31:0] w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clk_wait(4);
    chk("reset_r4", r4, 8'h00);
    chk("reset_wr", wr_strobe, 1'b0);

    w0 = wr_cnt;
    send(32'h8455, 16, 4);
    chk("duty_55", r4, 8'h55);
    chk("model_duty", mreg[4], 8'h55);
    chk("one_strobe", wr_cnt - w0, 1);
    chk("r0_untouched", r0, 8'h00);

    w0 = wr_cnt;
    send(32'h80A5, 16, 3);
    send(32'h815A, 16, 3);
    send(32'h82FF, 16, 2);
    send(32'h8301, 16, 5);
    chk("r0_A5", r0, 8'hA5);
    chk("r1_5A", r1, 8'h5A);
    chk("r2_FF", r2, 8'hFF);
    chk("r3_01", r3, 8'h01);
    chk("r4_kept", r4, 8'h55);
    chk("four_strobes", wr_cnt - w0, 4);

    e0 = err_cnt; w0 = wr_cnt;
    send(32'h0412, 16, 4);
    send(32'h8512, 16, 4);
    send(32'h8455 >> 1, 15, 4);
    send(32'h18455, 17, 4);
    chk("four_errs", err_cnt - e0, 4);
    chk("no_strobe_on_err", wr_cnt - w0, 0);
    chk("r4_after_err", r4, 8'h55);
    chk("r0_after_err", r0, 8'hA5);

    idle_toggles(12);
    send(32'h8133, 16, 4);
    chk("r1_33", r1, 8'h33);

    do_reset(3);
    chk("rst_r0", r0, 8'h00);
    chk("rst_r1", r1, 8'h00);
    chk("rst_r4", r4, 8'h00);

    e0 = err_cnt;
    send(32'h82, 8, 4, 0);
    do_reset(2);
    send(32'h8207, 16, 4);
    chk("abort_r2_07", r2, 8'h07);
    chk("abort_no_err", err_cnt - e0, 0);

    for (int k = 0; k < 40; k++) begin
      half = int'($urandom_range(2, 5));
      kind = int'($urandom_range(0, 9));
      n = (kind == 0) ? 15 : (kind == 1) ? 17 : 16;
      w = $urandom;
      if (kind >= 4) w[15] = 1'b1;
      if (kind >= 6) w[14:8] = 7'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) idle_toggles(int'($urandom_range(1, 4)));
      send(w, n, half);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
